// File: rtl/delta_load_sequencer.sv
// Read-side sequencer for the activation/start store: walks every row/address of
// one layer, issues load strobes and registers the returned vectors into a valid/ready stream.
module delta_load_sequencer #(
  parameter int data_size      = 16,
  parameter int size           = 3,
  parameter int max_layer_size = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [31:0]                 layer_len,
  input  logic [31:0]                 data_set,
  output logic                        load,
  output logic [31:0]                 load_address,
  output logic [31:0]                 load_row,
  output logic [31:0]                 load_data_set,
  input  logic [data_size*size-1:0]   load_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [data_size*size-1:0]   out_data,
  output logic [31:0]                 out_row,
  output logic [31:0]                 out_address,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [31:0] LastRow = 32'(size - 1);
  localparam logic [31:0] MaxLen  = 32'(max_layer_size);

  state_t      state;
  logic [31:0] len;
  logic        last_addr;
  logic        last_row;

  // NOTE: load is combinational so a low out_ready stalls the read in the same
  // cycle; registering it would let one extra beat slip past a full output stage.
  assign load      = (state == RUN) && !abort && (!out_valid || out_ready);
  assign busy      = (state != IDLE);
  assign last_addr = (load_address == len - 32'd1);
  assign last_row  = (load_row == LastRow);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge values of the counters and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len           <= '0;
      load_address  <= '0;
      load_row      <= '0;
      load_data_set <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_row       <= '0;
      out_address   <= '0;
      out_last      <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state        <= IDLE;
        out_valid    <= 1'b0;
        out_last     <= 1'b0;
        load_address <= '0;
        load_row     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              load_data_set <= data_set;
              load_address  <= '0;
              load_row      <= '0;
              len           <= (layer_len > MaxLen) ? MaxLen : layer_len;
              // An empty layer completes immediately without touching the store.
              if (layer_len == 32'd0) done  <= 1'b1;
              else                    state <= RUN;
            end
          end
          RUN: begin
            if (load) begin
              out_data    <= load_data;
              out_row     <= load_row;
              out_address <= load_address;
              out_valid   <= 1'b1;
              out_last    <= last_addr && last_row;
              if (last_addr) begin
                load_address <= '0;
                if (last_row) begin
                  load_row <= '0;
                  state    <= FLUSH;
                end else begin
                  load_row <= load_row + 32'd1;
                end
              end else begin
                load_address <= load_address + 32'd1;
              end
            end
          end
          FLUSH: begin
            if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
              done      <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_delta_load_sequencer.sv
// Scoreboard bench for delta_load_sequencer: a store model feeds load_data, the
// walk order is predicted into a queue and a negedge monitor checks every accepted beat.
module tb_delta_load_sequencer;

  localparam int DW = 16;
  localparam int SZ = 3;
  localparam int ML = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [31:0]       layer_len = '0;
  logic [31:0]       data_set = '0;
  logic              load;
  logic [31:0]       load_address;
  logic [31:0]       load_row;
  logic [31:0]       load_data_set;
  logic [DW*SZ-1:0]  load_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW*SZ-1:0]  out_data;
  logic [31:0]       out_row;
  logic [31:0]       out_address;
  logic              out_last;
  logic              busy;
  logic              done;

  delta_load_sequencer #(.data_size(DW), .size(SZ), .max_layer_size(ML)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .layer_len(layer_len), .data_set(data_set), .load(load),
    .load_address(load_address), .load_row(load_row), .load_data_set(load_data_set),
    .load_data(load_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_address(out_address),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               row;
    int               addr;
    logic [DW*SZ-1:0] data;
    bit               last;
  } beat_t;

  beat_t            exp_q[$];
  logic [DW*SZ-1:0] store [SZ][ML];
  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;
  int               hs_cnt = 0;
  int               done_cnt = 0;
  int               last_hs_cyc = 0;
  int               done_cyc = 0;
  bit               busy_seen = 0;
  bit               load_seen = 0;
  logic [31:0]      cur_ds = '0;
  int               ready_mode = 0;  // 0 high, 1 toggle, 2 random, 3 manual

  // Behavioural store: a combinational read of the addressed vector.
  always_comb begin
    load_data = '0;
    if (load_row < 32'(SZ) && load_address < 32'(ML))
      load_data = store[load_row[1:0]][load_address[2:0]];
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks stalls and data-set tag.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy) busy_seen = 1;
      if (load) begin
        load_seen = 1;
        check("load_data_set", load_data_set, cur_ds);
      end
      if (busy && out_valid && !out_ready) check("stall_load_low", load, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got row %0d addr %0d with no beat expected", out_row, out_address);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_row", out_row, e.row);
          check("beat_addr", out_address, e.addr);
          check("beat_data", out_data, e.data);
          check("beat_last", out_last, e.last);
          hs_cnt++;
          last_hs_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic fill_store();
    for (int r = 0; r < SZ; r++)
      for (int a = 0; a < ML; a++)
        store[r][a] = {$urandom, $urandom};
  endtask

  // Row-major walk of an (already clamped) layer, truncated to nmax beats.
  task automatic push_walk(int eff, int nmax);
    int n = 0;
    for (int r = 0; r < SZ; r++)
      for (int a = 0; a < eff; a++) begin
        beat_t b;
        if (n < nmax) begin
          b.row = r; b.addr = a; b.data = store[r][a];
          b.last = (r == SZ - 1) && (a == eff - 1);
          exp_q.push_back(b);
        end
        n++;
      end
  endtask

  task automatic pulse_start(int ll);
    @(posedge clk); #1;
    layer_len = 32'(ll);
    data_set  = cur_ds;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    layer_len = $urandom;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_load"}, load, 0);
    check({tag, "_load_address"}, load_address, 0);
    check({tag, "_load_row"}, load_row, 0);
    check({tag, "_load_data_set"}, load_data_set, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_address"}, out_address, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_pass(int ll, int mode, bit start_mid);
    int eff, hs0, d0, start_cyc;
    eff = (ll > ML) ? ML : ll;
    fill_store();
    cur_ds = $urandom;
    ready_mode = mode;
    push_walk(eff, SZ * ML);
    hs0 = hs_cnt; d0 = done_cnt;
    busy_seen = 0; load_seen = 0;
    pulse_start(ll);
    start_cyc = cyc;
    if (eff > 0) begin
      check("first_load", load, 1);
      check("first_row", load_row, 0);
      check("first_addr", load_address, 0);
    end
    if (start_mid) begin
      @(posedge clk); #1;
      start = 1'b1; layer_len = 32'd1; data_set = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("beat_count", hs_cnt - hs0, SZ * eff);
    check("queue_empty", exp_q.size(), 0);
    check("busy_after", busy, 0);
    if (eff > 0) begin
      check("done_timing", done_cyc, last_hs_cyc + 1);
    end else begin
      check("empty_done_timing", done_cyc, start_cyc);
      check("empty_busy_seen", busy_seen, 0);
      check("empty_load_seen", load_seen, 0);
    end
  endtask

  task automatic abort_test();
    int hs0, d0;
    fill_store();
    cur_ds = $urandom;
    ready_mode = 3;
    out_ready = 1'b1;
    push_walk(2, 3);
    hs0 = hs_cnt; d0 = done_cnt;
    pulse_start(2);
    for (int i = 0; i < 50 && hs_cnt - hs0 < 3; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("abort_pre_valid", out_valid, 1);
    check("abort_pre_row", out_row, 1);
    check("abort_pre_addr", out_address, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_busy", busy, 0);
    check("abort_load", load, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_beats", hs_cnt - hs0, 3);
    check("abort_queue", exp_q.size(), 0);
  endtask

  task automatic reset_in_flush_test();
    int hs0;
    fill_store();
    cur_ds = $urandom | 32'h1;
    ready_mode = 3;
    out_ready = 1'b1;
    push_walk(2, SZ * 2);
    hs0 = hs_cnt;
    pulse_start(2);
    for (int i = 0; i < 50 && hs_cnt - hs0 < 5; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("flush_busy", busy, 1);
    check("flush_valid", out_valid, 1);
    check("flush_last", out_last, 1);
    check("flush_row", out_row, SZ - 1);
    check("flush_addr", out_address, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    exp_q.delete();
    #3 reset_n = 1'b1;
  endtask

  initial begin
    fill_store();
    #3 check_reset_outputs("reset");
    #9 reset_n = 1'b1;

    run_pass(2, 0, 0);
    run_pass(2, 1, 0);
    run_pass(9, 0, 0);
    run_pass(0, 0, 0);
    abort_test();
    run_pass(2, 0, 0);
    run_pass(3, 2, 1);
    reset_in_flush_test();
    for (int k = 0; k < 12; k++) begin
      int ll;
      ll = $urandom_range(0, 9);
      run_pass(ll, 2, (ll >= 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
